// File: rtl/led_run_sched.sv
// Step scheduler for the 8-LED one-hot runner: prescaled step enable, run/pause/stop
// sequencing and position tracking. Define LED_SCHED_BOUNCE_EN for ping-pong auto-reverse.
module led_run_sched #(
  parameter int             CNT_W = 24,
  parameter logic [CNT_W-1:0] DIV0  = CNT_W'(12000000),
  parameter logic [CNT_W-1:0] DIV1  = CNT_W'(6000000),
  parameter logic [CNT_W-1:0] DIV2  = CNT_W'(3000000),
  parameter logic [CNT_W-1:0] DIV3  = CNT_W'(1000000)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       pause_i,
  input  logic       dir_i,
  input  logic [1:0] speed_i,
  input  logic       bounce_i,
  output logic       step_o,
  output logic       mode_o,
  output logic [2:0] pos_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] div_q, div_next, div_sel;
  logic             step_next, mode_next, busy_next;
  logic [2:0]       pos_next;
  logic             nd;
  logic             term;

  always_comb begin
    case (speed_i)
      2'd0:    div_sel = DIV0;
      2'd1:    div_sel = DIV1;
      2'd2:    div_sel = DIV2;
      default: div_sel = DIV3;
    endcase
  end

`ifdef LED_SCHED_BOUNCE_EN
  // Reverse at either end so the runner ping-pongs instead of wrapping.
  always_comb begin
    nd = dir_i;
    if (bounce_i) begin
      if (pos_o == 3'd7 && !mode_o)
        nd = 1'b1;
      else if (pos_o == 3'd0 && mode_o)
        nd = 1'b0;
      else
        nd = mode_o;
    end
  end
`else
  logic bounce_unused;
  assign bounce_unused = bounce_i;
  assign nd = dir_i;
`endif

  assign term = (cnt == div_q - CNT_W'(1));

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    div_next   = div_q;
    step_next  = 1'b0;
    mode_next  = mode_o;
    pos_next   = pos_o;
    if (stop_i) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !pause_i) begin
            state_next = RUN;
            cnt_next   = '0;
            div_next   = div_sel;
          end
        end
        RUN: begin
          // Pause freezes the count, even on the terminal-count cycle.
          if (pause_i) begin
            state_next = PAUSE;
          end else if (term) begin
            cnt_next  = '0;
            step_next = 1'b1;
            mode_next = nd;
            pos_next  = nd ? pos_o - 3'd1 : pos_o + 3'd1;
            div_next  = div_sel;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        PAUSE: begin
          if (pause_i)
            state_next = RUN;
        end
        default: state_next = IDLE;
      endcase
    end
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      div_q  <= DIV0;
      step_o <= 1'b0;
      mode_o <= 1'b0;
      pos_o  <= 3'd0;
      busy_o <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      div_q  <= div_next;
      step_o <= step_next;
      mode_o <= mode_next;
      pos_o  <= pos_next;
      busy_o <= busy_next;
    end
  end

endmodule

// File: tb/tb_led_run_sched.sv
// Directed bench for led_run_sched with short divisors (4/3/2/1): vector table plus
// hand-written sequences for pause on terminal count, async reset and bounce.
module tb_led_run_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i, stop_i, pause_i, dir_i, bounce_i;
  logic [1:0] speed_i;
  logic       step_o, mode_o, busy_o;
  logic [2:0] pos_o;

  led_run_sched #(
    .CNT_W(24), .DIV0(24'd4), .DIV1(24'd3), .DIV2(24'd2), .DIV3(24'd1)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .pause_i(pause_i),
    .dir_i(dir_i), .speed_i(speed_i), .bounce_i(bounce_i),
    .step_o(step_o), .mode_o(mode_o), .pos_o(pos_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start, stop, pause, dir;
    logic [1:0] speed;
    logic       e_step, e_mode;
    logic [2:0] e_pos;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   bpos[15];
  int   bmode[15];

  task automatic add(input int st, input int sp, input int pa, input int dr, input int spd,
                     input int es, input int em, input int ep, input int eb);
    vec_t v;
    v.start = 1'(st); v.stop = 1'(sp); v.pause = 1'(pa); v.dir = 1'(dr);
    v.speed = 2'(spd);
    v.e_step = 1'(es); v.e_mode = 1'(em); v.e_pos = 3'(ep); v.e_busy = 1'(eb);
    vecs.push_back(v);
  endtask

  function automatic logic [5:0] exp6(input int s, input int m, input int p, input int b);
    return {1'(s), 1'(m), 3'(p), 1'(b)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed as {step, mode, pos[2:0], busy}.
  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {step_o, mode_o, pos_o, busy_o};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got step/mode/pos/busy=%b required %b", name, act, exp);
    end else begin
      $display("ok   %s: step/mode/pos/busy=%b", name, act);
    end
  endtask

  task automatic idle_inputs();
    start_i = 1'b0; stop_i = 1'b0; pause_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle_inputs(); dir_i = 1'b0; speed_i = 2'd0; bounce_i = 1'b0;

    // Test 2: speed 0, dir 0, eight steps every 4 clocks, wrapping 7->0.
    add(1,0,0,0,0, 0,0,0,1);
    for (int k = 1; k <= 8; k++) begin
      for (int j = 0; j < 3; j++) add(0,0,0,0,0, 0,0,(k-1)%8,1);
      add(0,0,0,0,0, 1,0,k%8,1);
    end
    // Test 3: restart with dir 1, speed 3 -> step every cycle, 7,6,5.
    add(0,1,0,0,0, 0,0,0,0);
    add(1,0,0,1,3, 0,0,0,1);
    add(0,0,0,1,3, 1,1,7,1);
    add(0,0,0,1,3, 1,1,6,1);
    add(0,0,0,1,3, 1,1,5,1);
    // Test 4: speed 0 -> 2 mid-interval; first interval 4, then 2.
    add(0,1,0,1,3, 0,1,5,0);
    add(1,0,0,0,0, 0,1,5,1);
    add(0,0,0,0,0, 0,1,5,1);
    add(0,0,0,0,2, 0,1,5,1);
    add(0,0,0,0,2, 0,1,5,1);
    add(0,0,0,0,2, 1,0,6,1);
    add(0,0,0,0,2, 0,0,6,1);
    add(0,0,0,0,2, 1,0,7,1);
    add(0,0,0,0,2, 0,0,7,1);
    add(0,0,0,0,2, 1,0,0,1);
    // Test 5: pause at cnt=2 for 10 cycles (start ignored), resume, stop on terminal count.
    add(0,1,0,0,0, 0,0,0,0);
    add(1,0,0,0,0, 0,0,0,1);
    add(0,0,0,0,0, 0,0,0,1);
    add(0,0,0,0,0, 0,0,0,1);
    add(0,0,1,0,0, 0,0,0,1);
    for (int i = 0; i < 10; i++) add((i == 4) ? 1 : 0,0,0,0,0, 0,0,0,1);
    add(0,0,1,0,0, 0,0,0,1);
    add(0,0,0,0,0, 0,0,0,1);
    add(0,0,0,0,0, 1,0,1,1);
    for (int i = 0; i < 3; i++) add(0,0,0,0,0, 0,0,1,1);
    add(0,1,0,0,0, 0,0,1,0);
    add(0,0,0,0,0, 0,0,1,0);
    add(0,0,0,0,0, 0,0,1,0);

`ifdef LED_SCHED_BOUNCE_EN
    bpos  = '{1,2,3,4,5,6,7,6,5,4,3,2,1,0,1};
    bmode = '{0,0,0,0,0,0,0,1,1,1,1,1,1,1,0};
`else
    bpos  = '{1,2,3,4,5,6,7,0,1,2,3,4,5,6,7};
    bmode = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
`endif

    // Test 1: reset state and no activity for 20 cycles.
    repeat (3) tick();
    check("reset_held", exp6(0,0,0,0));
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("idle_after_reset_%0d", i), exp6(0,0,0,0));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      start_i = vecs[i].start; stop_i = vecs[i].stop; pause_i = vecs[i].pause;
      dir_i = vecs[i].dir; speed_i = vecs[i].speed;
      tick();
      check($sformatf("vec_%0d", i),
            {vecs[i].e_step, vecs[i].e_mode, vecs[i].e_pos, vecs[i].e_busy});
    end
    idle_inputs();

    // Pause landing on the terminal-count cycle suppresses that step.
    start_i = 1'b1; dir_i = 1'b0; speed_i = 2'd0;
    tick(); start_i = 1'b0;
    check("pt_start", exp6(0,0,1,1));
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("pt_count_%0d", i), exp6(0,0,1,1));
    end
    pause_i = 1'b1;
    tick(); pause_i = 1'b0;
    check("pt_pause_on_term", exp6(0,0,1,1));
    repeat (2) begin
      tick();
      check("pt_paused", exp6(0,0,1,1));
    end
    pause_i = 1'b1;
    tick(); pause_i = 1'b0;
    check("pt_resume", exp6(0,0,1,1));
    tick();
    check("pt_step_after_resume", exp6(1,0,2,1));
    stop_i = 1'b1; pause_i = 1'b1;
    tick(); idle_inputs();
    check("pt_stop_beats_pause", exp6(0,0,2,0));

    // Asynchronous reset mid-run.
    start_i = 1'b1; dir_i = 1'b1; speed_i = 2'd3;
    tick(); start_i = 1'b0;
    check("ar_start", exp6(0,0,2,1));
    tick();
    check("ar_step1", exp6(1,1,1,1));
    #2 rst = 1'b1;
    #1 check("ar_async_clear", exp6(0,0,0,0));
    #2 rst = 1'b0;
    tick();
    check("ar_idle_after", exp6(0,0,0,0));

    // Test 6: bounce request at speed 3, dir 0.
    bounce_i = 1'b1; dir_i = 1'b0; speed_i = 2'd3; start_i = 1'b1;
    tick(); start_i = 1'b0;
    check("bn_start", exp6(0,0,0,1));
    for (int k = 0; k < 15; k++) begin
      tick();
      check($sformatf("bn_step_%0d", k), exp6(1, bmode[k], bpos[k], 1));
    end
    stop_i = 1'b1;
    tick(); idle_inputs(); bounce_i = 1'b0;
    check("bn_stop", exp6(0, bmode[14], bpos[14], 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
